ysyx_22041071_axi_slave_mem: RTL and testbench
==============================================

// Module: ysyx_22041071_axi_slave_mem
// PURPOSE
//  AXI4 responder (slave) with a private single-port memory: the far end of the core's AXI read/write master.
//  Used as the simulation/test memory behind the CPU bus. Serves INCR bursts, full-width (8-byte) beats only.
//  Serves one transaction at a time; reads and writes share the array.
// PARAMETERS
//  ADDR_W     32            address width
//  DATA_W     64            data width; beat = DATA_W/8 bytes; wstrb width = DATA_W/8
//  MEM_DEPTH  4096          memory words (DATA_W each); must be a power of 2
//  BASE       32'h8000_0000 first byte address served; window = BASE .. BASE+MEM_DEPTH*8-1
// PORTS
//  clk      in   1        clock, all logic on rising edge
//  reset    in   1        asynchronous, active-high reset
//  arvalid  in   1        read address valid
//  arready  out  1        read address accepted
//  araddr   in   ADDR_W   burst start byte address (low 3 bits ignored)
//  arlen    in   8        beats-1
//  rvalid   out  1        read data valid
//  rready   in   1        master accepts read beat
//  rdata    out  DATA_W   read beat
//  rresp    out  2        00 OKAY, 10 SLVERR
//  rlast    out  1        final beat of burst
//  awvalid  in   1        write address valid
//  awready  out  1        write address accepted
//  awaddr   in   ADDR_W   burst start byte address (low 3 bits ignored)
//  awlen    in   8        beats-1
//  wvalid   in   1        write data valid
//  wready   out  1        slave accepts write beat
//  wdata    in   DATA_W   write beat
//  wstrb    in   DATA_W/8 byte enables
//  wlast    in   1        master's final-beat flag
//  bvalid   out  1        write response valid
//  bready   in   1        master accepts response
//  bresp    out  2        00 OKAY, 10 SLVERR
// BEHAVIOUR
//  - Reset: all outputs 0; FSM->IDLE; beat cnt=0; err=0; memory not cleared. Reset mid-burst aborts the burst; beats already written stay.
//  - en flop: 0 in reset, 1 from first clk after release. arready=en&IDLE&!awvalid; awready=en&IDLE (write wins a tie).
//  - FSM IDLE->RD on arvalid&arready; IDLE->WR on awvalid&awready. Latch addr word index, len. Clear cnt and err.
//  - Word index idx = (addr-BASE)>>3, +cnt, modulo MEM_DEPTH (wraps silently). Out-of-window start address sets err.
//  - RD: rvalid=1 from the cycle after the AR handshake. rdata=mem[idx+cnt], or 0 when err. rresp=err?10:00. rlast=(cnt==len).
//  - RD: cnt advances only on rvalid&rready. Outputs stay stable while rvalid&!rready. On the last handshake -> IDLE with rvalid=0 the next cycle.
//  - RD throughput: len+1 beats in len+1 cycles with rready held high.
//  - WR: wready=1. On wvalid&wready, write the bytes selected by wstrb to mem[idx+cnt] (suppressed when err); cnt++.
//  - WR end: the burst ends on the beat where cnt==len, regardless of wlast; ->WRESP.
//  - WR wlast mismatch: wlast!=(cnt==len) on any beat sets err (sticky).
//  - WRESP: bvalid=1 from the cycle after the last W beat; bresp=err?10:00. On bready -> IDLE.
//  - No W data is accepted before the AW handshake (wready=0 outside WR).
//  - cnt is 8 bits; len=255 gives 256 beats with no overflow.
// TESTING
//  1. Single write: AW 0x8000_0010 len0, W 0x1122334455667788 strb FF last1 -> bvalid next cycle, bresp 00; read back the same data, rlast=1.
//  2. Burst: write 4 beats (len3) at 0x8000_0100 with values 1..4 -> bresp 00. Read len3 with rready toggling 1/0 -> rdata 1,2,3,4 held while stalled, rlast only on beat 4.
//  3. Partial strobe: write 0xFFFF..FF strb 0F over 0 -> read returns 0x00000000FFFFFFFF.
//  4. Tie and range: arvalid and awvalid in the same cycle -> awready=1, arready=0, read served after B. Read at 0x7000_0000 -> rresp 10, rdata 0.
//  5. Errors: len1 write with wlast on beat 0 -> two beats accepted, bresp 10. Burst at word MEM_DEPTH-1 len1 -> second beat wraps to word 0.
//  6. Reset asserted during beat 2 of a len7 read -> rvalid=0 immediately; after release arready=1 exactly one clk later.

Source files
------------

// File: rtl/ysyx_22041071_axi_slave_mem_if.sv
// rtl/ysyx_22041071_axi_slave_mem_if.sv - AXI4 read/write channel bundle between a bus master and the memory responder
//
// Channels carried (master -> slave unless noted):
//   AR: arvalid, araddr, arlen            / arready (slave -> master)
//   R : rready                            / rvalid, rdata, rresp, rlast (slave -> master)
//   AW: awvalid, awaddr, awlen            / awready (slave -> master)
//   W : wvalid, wdata, wstrb, wlast       / wready (slave -> master)
//   B : bready                            / bvalid, bresp (slave -> master)
interface ysyx_22041071_axi_slave_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport slave (
    input  arvalid, araddr, arlen, rready,
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast,
    output awready, wready, bvalid, bresp
  );

  modport master (
    output arvalid, araddr, arlen, rready,
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast,
    input  awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_22041071_axi_slave_mem.sv
// rtl/ysyx_22041071_axi_slave_mem.sv - AXI4 INCR-burst responder backed by a private single-port memory
//
// Ports:
//   clk    - clock, all state on the rising edge
//   reset  - asynchronous, active-high; aborts any burst, memory contents kept
//   bus    - slave side of ysyx_22041071_axi_slave_mem_if (AR/R/AW/W/B channels)
// One transaction at a time; reads and writes share the array. Full-width beats only.
// Start addresses outside BASE .. BASE+MEM_DEPTH*8-1 are answered with SLVERR.
module ysyx_22041071_axi_slave_mem #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 64,
  parameter int              MEM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000
) (
  input logic                        clk,
  input logic                        reset,
  ysyx_22041071_axi_slave_mem_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(MEM_DEPTH * STRB_W);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WRESP} state_t;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [DATA_W-1:0]  mem [MEM_DEPTH];

  logic               aw_hs, ar_hs;
  logic               is_last;
  logic               mem_we;
  logic [IDX_W-1:0]   word_idx;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  start_off;
  logic               start_ok;
  logic [IDX_W-1:0]   start_idx;

  // en holds off both address channels until the first clock after reset release.
  assign bus.awready = en_q && (state_q == S_IDLE);
  assign bus.arready = en_q && (state_q == S_IDLE) && !bus.awvalid;
  assign aw_hs       = bus.awvalid && bus.awready;
  assign ar_hs       = bus.arvalid && bus.arready;

  // Subtracting BASE turns addresses below the window into huge offsets,
  // so one unsigned compare covers both ends of the window.
  assign start_addr = aw_hs ? bus.awaddr : bus.araddr;
  assign start_off  = start_addr - BASE;
  assign start_ok   = (start_off < WIN_BYTES);
  assign start_idx  = start_off[IDX_W+OFF_W-1:OFF_W];

  // Word address wraps modulo MEM_DEPTH through the natural IDX_W-bit add.
  assign word_idx = idx_q + IDX_W'(cnt_q);
  assign is_last  = (cnt_q == len_q);

  assign bus.rvalid = (state_q == S_RD);
  assign bus.rlast  = bus.rvalid && is_last;
  assign bus.rresp  = (bus.rvalid && err_q) ? 2'b10 : 2'b00;
  assign bus.rdata  = (bus.rvalid && !err_q) ? mem[word_idx] : '0;

  assign bus.wready = (state_q == S_WR);

  assign bus.bvalid = (state_q == S_WRESP);
  assign bus.bresp  = (bus.bvalid && err_q) ? 2'b10 : 2'b00;

  always_comb begin
    state_d = state_q;
    en_d    = 1'b1;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          state_d = S_WR;
          idx_d   = start_idx;
          len_d   = bus.awlen;
          cnt_d   = 8'd0;
          err_d   = !start_ok;
        end else if (ar_hs) begin
          state_d = S_RD;
          idx_d   = start_idx;
          len_d   = bus.arlen;
          cnt_d   = 8'd0;
          err_d   = !start_ok;
        end
      end
      S_RD: begin
        if (bus.rready) begin
          if (is_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_WR: begin
        if (bus.wvalid) begin
          mem_we = !err_q;
          // The beat count, not wlast, ends the burst; a disagreeing wlast only poisons bresp.
          if (bus.wlast != is_last) begin
            err_d = 1'b1;
          end
          if (is_last) begin
            state_d = S_WRESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_WRESP: begin
        if (bus.bready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      idx_q   <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b]) begin
          mem[word_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_slave_mem.sv
// tb/tb_ysyx_22041071_axi_slave_mem.sv - randomized self-checking bench for the AXI memory responder
module tb_ysyx_22041071_axi_slave_mem;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22041071_axi_slave_mem_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  ysyx_22041071_axi_slave_mem #(
    .ADDR_W(32), .DATA_W(64), .MEM_DEPTH(DEPTH), .BASE(BASE)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory: value plus per-byte "known" flags (array is never cleared).
  logic [63:0] model [DEPTH];
  logic [7:0]  known [DEPTH];
  logic [63:0] wbuf  [256];
  logic [7:0]  sbuf  [256];

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH * 8));
  endfunction

  function automatic int word_of(input logic [31:0] a, input int k);
    return int'((((a - BASE) >> 3) + 32'(k)) % 32'(DEPTH));
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{known[w][b]}};
    return m;
  endfunction

  task automatic idle_bus();
    bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.rready = 0;
    bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
  endtask

  // bad_beat >= 0 flips wlast on that beat.
  task automatic write_burst(input logic [31:0] addr, input int len, input int bad_beat,
                             input int gap_pct, input bit chk_b_next, input string name);
    bit got;
    int waited;
    bit exp_err;
    int w;
    bus.awvalid = 1; bus.awaddr = addr; bus.awlen = len[7:0];
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.awready) begin got = 1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL %s_aw: awready=0 required=1", name); end
    @(posedge clk); #1;
    bus.awvalid = 0;
    for (int k = 0; k <= len; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.wvalid = 0; @(posedge clk); #1;
      end
      bus.wvalid = 1; bus.wdata = wbuf[k]; bus.wstrb = sbuf[k];
      bus.wlast = (bad_beat == k) ? (k != len) : (k == len);
      got = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.wready) begin got = 1; break; end
      end
      total++;
      if (!got) begin bad++; $display("FAIL %s_w%0d: wready=0 required=1", name, k); end
      @(posedge clk); #1;
    end
    bus.wvalid = 0; bus.wlast = 0;
    exp_err = !in_win(addr) || (bad_beat >= 0);
    if (in_win(addr)) begin
      for (int k = 0; k <= len; k++) begin
        w = word_of(addr, k);
        if (bad_beat >= 0) known[w] = 8'h00;
        else for (int b = 0; b < 8; b++)
          if (sbuf[k][b]) begin model[w][b*8 +: 8] = wbuf[k][b*8 +: 8]; known[w][b] = 1'b1; end
      end
    end
    waited = 0; got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.bvalid) begin got = 1; break; end
      waited++;
    end
    total++;
    if (!got) begin bad++; $display("FAIL %s_bvalid: timeout required=1", name); end
    if (chk_b_next) begin
      total++;
      if (waited !== 0) begin bad++; $display("FAIL %s_b_latency: waited=%0d required=0", name, waited); end
    end
    total++;
    if (bus.bresp !== (exp_err ? 2'b10 : 2'b00)) begin
      bad++; $display("FAIL %s_bresp: got=%b required=%b", name, bus.bresp, exp_err ? 2'b10 : 2'b00);
    end
    repeat ($urandom_range(2)) @(negedge clk);
    bus.bready = 1;
    @(posedge clk); #1;
    bus.bready = 0;
    total++;
    if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL %s_b_drop: bvalid=%b required=0", name, bus.bvalid); end
  endtask

  // mode 0: rready always 1, 1: toggle 1/0, 2: random
  task automatic read_burst(input logic [31:0] addr, input int len, input int mode,
                            input bit chk_thru, input string name);
    bit got;
    int beat, cycles, w;
    bit rr, exp_err;
    logic [63:0] exp_d, m;
    bus.arvalid = 1; bus.araddr = addr; bus.arlen = len[7:0];
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.arready) begin got = 1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL %s_ar: arready=0 required=1", name); end
    @(posedge clk); #1;
    bus.arvalid = 0;
    exp_err = !in_win(addr);
    beat = 0; cycles = 0;
    while (beat <= len && cycles < 2000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cycles % 2 == 0) : 1'($urandom_range(1));
      bus.rready = rr;
      @(negedge clk);
      cycles++;
      w = word_of(addr, beat);
      exp_d = exp_err ? 64'h0 : model[w];
      m = exp_err ? '1 : mask_of(w);
      total++;
      if (bus.rvalid !== 1'b1) begin bad++; $display("FAIL %s_rvalid%0d: got=%b required=1", name, beat, bus.rvalid); end
      total++;
      if ((bus.rdata & m) !== (exp_d & m)) begin
        bad++; $display("FAIL %s_rdata%0d: got=%h required=%h", name, beat, bus.rdata & m, exp_d & m);
      end
      total++;
      if (bus.rresp !== (exp_err ? 2'b10 : 2'b00)) begin
        bad++; $display("FAIL %s_rresp%0d: got=%b required=%b", name, beat, bus.rresp, exp_err ? 2'b10 : 2'b00);
      end
      total++;
      if (bus.rlast !== (beat == len)) begin
        bad++; $display("FAIL %s_rlast%0d: got=%b required=%b", name, beat, bus.rlast, beat == len);
      end
      if (rr) beat++;
      @(posedge clk); #1;
    end
    bus.rready = 0;
    total++;
    if (beat <= len) begin bad++; $display("FAIL %s_timeout: beats=%0d required=%0d", name, beat, len + 1); end
    total++;
    if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL %s_r_drop: rvalid=%b required=0", name, bus.rvalid); end
    if (chk_thru) begin
      total++;
      if (cycles !== len + 1) begin bad++; $display("FAIL %s_thru: cycles=%0d required=%0d", name, cycles, len + 1); end
    end
  endtask

  task automatic test_reset();
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid, bus.rlast} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got=%b required=000000",
        {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid, bus.rlast});
    end
    total++;
    if ({bus.rdata, bus.rresp, bus.bresp} !== 68'h0) begin
      bad++; $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b required=0", bus.rdata, bus.rresp, bus.bresp);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    total++;
    if (bus.arready !== 1'b0) begin bad++; $display("FAIL reset_en0: arready=%b required=0", bus.arready); end
    @(negedge clk);
    total++;
    if ({bus.arready, bus.awready} !== 2'b11) begin
      bad++; $display("FAIL reset_en1: arready,awready=%b required=11", {bus.arready, bus.awready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    wbuf[0] = 64'h1122_3344_5566_7788; sbuf[0] = 8'hFF;
    write_burst(32'h8000_0010, 0, -1, 0, 1, "single");
    read_burst(32'h8000_0010, 0, 0, 1, "single_rd");
  endtask

  task automatic test_burst();
    for (int k = 0; k < 4; k++) begin wbuf[k] = 64'(k + 1); sbuf[k] = 8'hFF; end
    write_burst(32'h8000_0100, 3, -1, 30, 0, "burst");
    read_burst(32'h8000_0100, 3, 1, 0, "burst_rd");
  endtask

  task automatic test_partial();
    wbuf[0] = 64'h0; sbuf[0] = 8'hFF;
    write_burst(32'h8000_0020, 0, -1, 0, 0, "part0");
    wbuf[0] = '1; sbuf[0] = 8'h0F;
    write_burst(32'h8000_0020, 0, -1, 0, 0, "part1");
    read_burst(32'h8000_0020, 0, 2, 0, "part_rd");
  endtask

  task automatic test_tie();
    logic [63:0] d;
    int w;
    d = {$urandom, $urandom};
    bus.arvalid = 1; bus.araddr = 32'h8000_0040; bus.arlen = 0;
    bus.awvalid = 1; bus.awaddr = 32'h8000_0040; bus.awlen = 0;
    @(negedge clk);
    total++;
    if ({bus.awready, bus.arready} !== 2'b10) begin
      bad++; $display("FAIL tie_ready: awready,arready=%b required=10", {bus.awready, bus.arready});
    end
    @(posedge clk); #1;
    bus.awvalid = 0;
    bus.wvalid = 1; bus.wdata = d; bus.wstrb = 8'hFF; bus.wlast = 1;
    @(negedge clk);
    total++;
    if ({bus.wready, bus.arready} !== 2'b10) begin
      bad++; $display("FAIL tie_wr: wready,arready=%b required=10", {bus.wready, bus.arready});
    end
    @(posedge clk); #1;
    bus.wvalid = 0; bus.wlast = 0;
    w = word_of(32'h8000_0040, 0);
    model[w] = d; known[w] = 8'hFF;
    @(negedge clk);
    total++;
    if ({bus.bvalid, bus.bresp, bus.arready} !== 4'b1000) begin
      bad++; $display("FAIL tie_b: bvalid,bresp,arready=%b required=1000", {bus.bvalid, bus.bresp, bus.arready});
    end
    bus.bready = 1;
    @(posedge clk); #1;
    bus.bready = 0;
    @(negedge clk);
    total++;
    if (bus.arready !== 1'b1) begin bad++; $display("FAIL tie_ar_after_b: arready=%b required=1", bus.arready); end
    @(posedge clk); #1;
    bus.arvalid = 0; bus.rready = 1;
    @(negedge clk);
    total++;
    if ({bus.rvalid, bus.rlast} !== 2'b11 || bus.rdata !== d) begin
      bad++; $display("FAIL tie_rd: rvalid,rlast=%b rdata=%h required=11 %h", {bus.rvalid, bus.rlast}, bus.rdata, d);
    end
    @(posedge clk); #1;
    bus.rready = 0;
  endtask

  task automatic test_wrap_and_range();
    logic [31:0] top_addr;
    top_addr = BASE + 32'((DEPTH - 1) * 8);
    wbuf[0] = {$urandom, $urandom}; wbuf[1] = {$urandom, $urandom};
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    write_burst(top_addr, 1, -1, 0, 0, "wrap");
    read_burst(top_addr, 1, 0, 1, "wrap_rd");
    read_burst(BASE, 0, 0, 0, "wrap_w0");
    read_burst(32'h7000_0000, 2, 2, 0, "range_rd");
    // Out-of-window write whose offset would alias word 0 must be dropped.
    wbuf[0] = {$urandom, $urandom}; sbuf[0] = 8'hFF;
    write_burst(32'h9000_0000, 0, -1, 0, 0, "range_wr");
    read_burst(BASE, 0, 0, 0, "range_keep");
  endtask

  task automatic test_wlast_errors();
    for (int k = 0; k < 3; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'hFF; end
    write_burst(32'h8000_0200, 1, 0, 0, 1, "wlast_early");
    write_burst(32'h8000_0300, 2, 2, 20, 1, "wlast_missing");
    wbuf[0] = {$urandom, $urandom};
    write_burst(32'h8000_0380, 0, -1, 0, 1, "after_err");
    read_burst(32'h8000_0380, 0, 0, 0, "after_err_rd");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int len;
    for (int k = 0; k < 256; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'hFF; end
    write_burst(BASE + 32'(512 * 8), 255, -1, 0, 1, "fill255");
    read_burst(BASE + 32'(512 * 8), 255, 0, 1, "read255");
    for (int it = 0; it < 24; it++) begin
      a = BASE + 32'((512 + $urandom_range(0, 239)) * 8) + 32'($urandom_range(7));
      len = $urandom_range(15);
      if ($urandom_range(1) == 1) begin
        for (int k = 0; k <= len; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'($urandom); end
        write_burst(a, len, -1, 25, 0, "rand_wr");
      end else begin
        read_burst(a, len, 2, 0, "rand_rd");
      end
    end
  endtask

  task automatic test_reset_mid();
    int beat;
    bit got;
    for (int k = 0; k < 8; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'hFF; end
    write_burst(32'h8000_0400, 7, -1, 0, 0, "mid_fill");
    bus.arvalid = 1; bus.araddr = 32'h8000_0400; bus.arlen = 8'd7;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.arready) begin got = 1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL mid_ar: arready=0 required=1"); end
    @(posedge clk); #1;
    bus.arvalid = 0; bus.rready = 1;
    beat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (beat == 2) break;
      if (bus.rvalid) beat++;
      @(posedge clk); #1;
    end
    rst = 1;
    #1;
    total++;
    if ({bus.rvalid, bus.arready, bus.awready} !== 3'b000) begin
      bad++; $display("FAIL mid_rst: rvalid,arready,awready=%b required=000", {bus.rvalid, bus.arready, bus.awready});
    end
    bus.rready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    total++;
    if (bus.arready !== 1'b0) begin bad++; $display("FAIL mid_en0: arready=%b required=0", bus.arready); end
    @(negedge clk);
    total++;
    if (bus.arready !== 1'b1) begin bad++; $display("FAIL mid_en1: arready=%b required=1", bus.arready); end
    @(posedge clk); #1;
    read_burst(32'h8000_0400, 7, 0, 1, "mid_keep");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin model[i] = '0; known[i] = 8'h00; end
    test_reset();
    test_single();
    test_burst();
    test_partial();
    test_tie();
    test_wrap_and_range();
    test_wlast_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
